rr_port_scheduler: RTL
======================

RR_PORT_SCHEDULER -- requirements
Module: rr_port_scheduler

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3, number of input ports arbitrated, legal range 2..16.
REQ-002 SHALL have parameter MAX_HOLD, default 64, maximum consecutive locked cycles without a transfer before forced release, legal range 2..65535.
REQ-003 SHALL have derived localparam SEL_W = clog2(NUM_PORTS), select width.
REQ-004 SHALL have port: clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: req  input  NUM_PORTS  per-port "flit available" request.
REQ-007 SHALL have port: tail  input  NUM_PORTS  per-port "current flit is last of packet".
REQ-008 SHALL have port: out_ready  input  1  downstream accepts a flit this cycle.
REQ-009 SHALL have port: out_valid  output  1  a port is granted and its flit is forwarded.
REQ-010 SHALL have port: grant  output  NUM_PORTS  one-hot granted port, all-zero when not valid.
REQ-011 SHALL have port: select  output  SEL_W  binary index of the granted port, 0 when not valid.
REQ-012 SHALL have port: timeout  output  1  one-cycle pulse on forced release.

Function
REQ-013 SHALL implement two states: IDLE (no grant) and LOCKED (one port owns the output until its tail flit transfers).
REQ-014 SHALL drive out_valid, grant and select from registers; out_valid SHALL be 1 exactly in LOCKED; grant and select SHALL always agree.
REQ-015 SHALL define a transfer as out_valid && out_ready in the same cycle.
REQ-016 SHALL, in IDLE with any req bit set at cycle t, grant the first requesting port at or after pointer, searching upward with wrap from NUM_PORTS-1 to 0, and enter LOCKED with grant visible at t+1.
REQ-017 SHALL, in IDLE with req all-zero, stay in IDLE.
REQ-018 SHALL, in LOCKED, hold grant regardless of req, including req of the owner dropping mid-packet.
REQ-019 SHALL, on a transfer with tail[select]=1, set pointer to (select+1) mod NUM_PORTS and re-arbitrate in the same cycle from that new pointer: any req set -> LOCKED with the new grant next cycle (zero-bubble handoff); none set -> IDLE.
REQ-020 SHALL allow the releasing port to win again in the same-cycle re-arbitration only when no other port requests.
REQ-021 SHALL keep a hold counter, cleared on entry to LOCKED and on every transfer, incremented on each LOCKED cycle without a transfer, saturating at MAX_HOLD.
REQ-022 SHALL, when the hold counter reaches MAX_HOLD, force release exactly as a tail transfer (REQ-019) and pulse timeout for one cycle.
REQ-023 SHALL give a tail transfer priority over the timeout when both occur in the same cycle; timeout SHALL then stay 0.
REQ-024 SHALL ignore tail bits of non-granted ports and tail of the owner when no transfer occurs.
REQ-025 SHALL never drive X or Z on any output.

Reset
REQ-026 SHALL, while reset=1 at a clock edge, set state IDLE, pointer 0, hold counter 0, out_valid 0, grant 0, select 0, timeout 0.
REQ-027 SHALL, on reset asserted mid-packet, abandon the lock; the first grant is possible at the second edge after reset deasserts (arbitrate at first edge, visible after).

Structure
REQ-028 SHALL place the state enum (IDLE, LOCKED) and the index-width function in shared package noc_sched_pkg.
REQ-029 SHALL implement the wrap-around priority search as one combinational sub-module rr_pick (inputs req, pointer; outputs any, index, one-hot), instantiated once.

Verification (NUM_PORTS=3, MAX_HOLD=8)
REQ-030 SHALL cover: reset, req=3'b110 at t, out_ready=1 -> grant=3'b010, select=1 at t+1.
REQ-031 SHALL cover: port1 locked, req=3'b111, tail[1]=1 on transfer -> next cycle grant=3'b100, out_valid stays 1 (no bubble); after port2 tail with req=3'b011 -> grant=3'b001 (wrap).
REQ-032 SHALL cover: port0 locked, out_ready=0 for 8 cycles -> timeout pulses once, then grant passes to the next requester, pointer=1.
REQ-033 SHALL cover: port0 locked, req[0] drops to 0 mid-packet, req=3'b010 -> grant stays 3'b001 until tail[0] transfers.
REQ-034 SHALL cover: reset asserted while LOCKED with req=3'b111 -> outputs 0 at the next edge; after release, first grant is port0.
REQ-035 SHALL cover: tail transfer and hold counter reaching MAX_HOLD in the same cycle -> normal release, timeout=0.

Source files
------------

// File: rtl/noc_sched_pkg.sv
// Shared definitions for the NoC port scheduler: arbiter state encoding and
// the helper that sizes port-index buses.
package noc_sched_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } sched_state_t;

    // Width of a binary port index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_port_scheduler_pick.sv
// Wrap-around priority search: first set req bit at or above pointer,
// wrapping from NUM_PORTS-1 back to 0.
module rr_pick
    import noc_sched_pkg::*;
#(
    parameter  int NUM_PORTS = 3,
    localparam int SEL_W     = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [SEL_W-1:0]     pointer,
    output logic                 any,
    output logic [SEL_W-1:0]     index,
    output logic [NUM_PORTS-1:0] one_hot
);

    logic [2*NUM_PORTS-1:0] doubled;
    logic [NUM_PORTS-1:0]   rotated;
    logic [SEL_W-1:0]       offset;
    logic [SEL_W:0]         sum;

    // Bit k of rotated is req[(pointer + k) mod NUM_PORTS].
    assign doubled = {req, req} >> pointer;
    assign rotated = doubled[NUM_PORTS-1:0];
    assign any     = |req;

    always_comb begin
        offset = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                offset = SEL_W'(k);
            end
        end
        sum = {1'b0, pointer} + {1'b0, offset};
        if (sum >= (SEL_W + 1)'(NUM_PORTS)) begin
            sum = sum - (SEL_W + 1)'(NUM_PORTS);
        end
        index = sum[SEL_W-1:0];
    end

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_onehot
            assign one_hot[gi] = any && (index == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/rr_port_scheduler.sv
// Packet-level round-robin output scheduler: a granted port keeps the output
// until its tail flit transfers or it stalls for MAX_HOLD cycles.
module rr_port_scheduler
    import noc_sched_pkg::*;
#(
    parameter  int NUM_PORTS = 3,
    parameter  int MAX_HOLD  = 64,
    localparam int SEL_W     = idx_width(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] tail,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [NUM_PORTS-1:0] grant,
    output logic [SEL_W-1:0]     select,
    output logic                 timeout
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    sched_state_t         state_reg,   state_next;
    logic [SEL_W-1:0]     pointer_reg, pointer_next;
    logic [HOLD_W-1:0]    hold_reg,    hold_next;
    logic [NUM_PORTS-1:0] grant_reg,   grant_next;
    logic [SEL_W-1:0]     select_reg,  select_next;
    logic                 timeout_reg, timeout_next;

    logic                 locked;
    logic                 transfer;
    logic                 tail_xfer;
    logic                 force_release;
    logic                 release_now;
    logic                 arb_en;
    logic [SEL_W-1:0]     ptr_after;
    logic [SEL_W-1:0]     arb_ptr;
    logic                 pick_any;
    logic [SEL_W-1:0]     pick_index;
    logic [NUM_PORTS-1:0] pick_one_hot;

    assign locked        = (state_reg == ST_LOCKED);
    assign transfer      = locked && out_ready;
    assign tail_xfer     = transfer && tail[select_reg];
    // A tail transfer in the same cycle wins, so no timeout is reported then.
    assign force_release = locked && !tail_xfer && (hold_reg == HOLD_W'(MAX_HOLD));
    assign release_now   = tail_xfer || force_release;
    assign arb_en        = !locked || release_now;
    assign ptr_after     = (select_reg == SEL_W'(NUM_PORTS - 1)) ? '0 : select_reg + 1'b1;
    assign arb_ptr       = release_now ? ptr_after : pointer_reg;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_pick (
        .req     (req),
        .pointer (arb_ptr),
        .any     (pick_any),
        .index   (pick_index),
        .one_hot (pick_one_hot)
    );

    always_comb begin
        state_next   = state_reg;
        pointer_next = pointer_reg;
        hold_next    = hold_reg;
        grant_next   = grant_reg;
        select_next  = select_reg;
        timeout_next = force_release;

        if (release_now) begin
            pointer_next = ptr_after;
        end

        if (arb_en) begin
            hold_next = '0;
            if (pick_any) begin
                state_next  = ST_LOCKED;
                grant_next  = pick_one_hot;
                select_next = pick_index;
            end else begin
                state_next  = ST_IDLE;
                grant_next  = '0;
                select_next = '0;
            end
        end else if (transfer) begin
            hold_next = '0;
        end else if (hold_reg != HOLD_W'(MAX_HOLD)) begin
            hold_next = hold_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            pointer_reg <= '0;
            hold_reg    <= '0;
            grant_reg   <= '0;
            select_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pointer_reg <= pointer_next;
            hold_reg    <= hold_next;
            grant_reg   <= grant_next;
            select_reg  <= select_next;
            timeout_reg <= timeout_next;
        end
    end

    assign out_valid = locked;
    assign grant     = grant_reg;
    assign select    = select_reg;
    assign timeout   = timeout_reg;

endmodule
